tbufcam_mt: RTL and testbench

//  Multi-thread, multi-port address CAM for tracking in-flight buffer addresses per thread.

---
 rtl/tbufcam_mt.sv | 182 ++++++++++++++++++
 tb/tb_tbufcam_mt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tbufcam_mt.sv
// tbufcam_mt
//   Multi-thread, multi-port address CAM that tracks in-flight buffer
//   addresses per hardware thread. Each thread owns a DEPTH-entry slot pool
//   used as a FIFO: allocation at the tail, in-order retire at the head.
//   A whole thread can be flushed on an exception. NCHK lookup ports are
//   searched in parallel against the registered state of every thread.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   except, except_thread flush all entries of one thread on the next edge
//   new_en, new_addr,     allocation request; new_ok (comb) reports that the
//   new_thread, new_ok    request was accepted (inserted, or already present)
//   ret_en, ret_thread    release the oldest entry of a thread
//   chk_addr              NCHK lookup addresses, port p = [p*WIDTH +: WIDTH]
//   chk_match             per port: hit on a valid entry of any thread
//   chk_match_thr         bit p*THREADS+t: port p hits a valid entry of thread t
//   free                  new_thread has at least one free slot
//   full, cnt             per-thread full flag and occupancy (CW bits each)

module tbufcam_mt #(
    parameter int WIDTH   = 11,
    parameter int THREADS = 2,
    parameter int DEPTH   = 4,
    parameter int NCHK    = 2,
    localparam int TW     = (THREADS > 1) ? $clog2(THREADS) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    except,
    input  logic [TW-1:0]           except_thread,
    input  logic                    new_en,
    input  logic [WIDTH-1:0]        new_addr,
    input  logic [TW-1:0]           new_thread,
    output logic                    new_ok,
    input  logic                    ret_en,
    input  logic [TW-1:0]           ret_thread,
    input  logic [NCHK*WIDTH-1:0]   chk_addr,
    output logic [NCHK-1:0]         chk_match,
    output logic [NCHK*THREADS-1:0] chk_match_thr,
    output logic                    free,
    output logic [THREADS-1:0]      full,
    output logic [THREADS*CW-1:0]   cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    // One extra bit so that thread ids at or above THREADS can be detected
    // even when THREADS is not a power of two.
    localparam logic [TW:0]   THR_LIM = (TW + 1)'(THREADS);

    logic [WIDTH-1:0] addr_q  [THREADS][DEPTH];
    logic [DEPTH-1:0] valid_q [THREADS];
    logic [DEPTH-1:0] valid_d [THREADS];
    logic [PW-1:0]    head_q  [THREADS];
    logic [PW-1:0]    head_d  [THREADS];
    logic [PW-1:0]    tail_q  [THREADS];
    logic [PW-1:0]    tail_d  [THREADS];
    logic [CW-1:0]    cnt_q   [THREADS];
    logic [CW-1:0]    cnt_d   [THREADS];

    logic [THREADS-1:0] ins;
    logic [THREADS-1:0] ret;
    logic [THREADS-1:0] flush;
    logic               dup;
    logic               new_in_rng;

    // Allocation decision. Duplicate detection only looks at the requesting
    // thread, so the same address may live in several threads at once.
    // A duplicate is accepted even when the thread is full.
    always_comb begin
        new_in_rng = ({1'b0, new_thread} < THR_LIM);
        dup        = 1'b0;
        free       = 1'b0;
        for (int t = 0; t < THREADS; t++) begin
            if (new_thread == TW'(t)) begin
                free = (cnt_q[t] != DEPTH_C);
                for (int d = 0; d < DEPTH; d++) begin
                    if (valid_q[t][d] && (addr_q[t][d] == new_addr)) begin
                        dup = 1'b1;
                    end
                end
            end
        end
        new_ok = new_en && new_in_rng && (dup || free) &&
                 !(except && (except_thread == new_thread));
    end

    // Next-state per thread. Flush wins over insert/retire on the same
    // thread; insert is already blocked there through new_ok.
    always_comb begin
        ins   = '0;
        ret   = '0;
        flush = '0;
        for (int t = 0; t < THREADS; t++) begin
            flush[t] = except && (except_thread == TW'(t));
            ins[t]   = new_ok && !dup && (new_thread == TW'(t));
            ret[t]   = ret_en && (ret_thread == TW'(t)) &&
                       (cnt_q[t] != '0) && !flush[t];

            valid_d[t] = valid_q[t];
            head_d[t]  = head_q[t];
            tail_d[t]  = tail_q[t];
            cnt_d[t]   = cnt_q[t];

            if (flush[t]) begin
                valid_d[t] = '0;
                head_d[t]  = '0;
                tail_d[t]  = '0;
                cnt_d[t]   = '0;
            end else begin
                if (ret[t]) begin
                    valid_d[t][head_q[t]] = 1'b0;
                    head_d[t]             = head_q[t] + PW'(1);
                end
                if (ins[t]) begin
                    valid_d[t][tail_q[t]] = 1'b1;
                    tail_d[t]             = tail_q[t] + PW'(1);
                end
                if (ins[t] && !ret[t]) begin
                    cnt_d[t] = cnt_q[t] + CW'(1);
                end else if (ret[t] && !ins[t]) begin
                    cnt_d[t] = cnt_q[t] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < THREADS; t++) begin
                valid_q[t] <= '0;
                head_q[t]  <= '0;
                tail_q[t]  <= '0;
                cnt_q[t]   <= '0;
            end
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                valid_q[t] <= valid_d[t];
                head_q[t]  <= head_d[t];
                tail_q[t]  <= tail_d[t];
                cnt_q[t]   <= cnt_d[t];
            end
        end
    end

    // Address storage needs no reset: every read is qualified by valid.
    always_ff @(posedge clk) begin
        for (int t = 0; t < THREADS; t++) begin
            if (ins[t]) begin
                addr_q[t][tail_q[t]] <= new_addr;
            end
        end
    end

    // Lookups see registered state only; no bypass of the incoming address.
    always_comb begin
        chk_match_thr = '0;
        chk_match     = '0;
        for (int p = 0; p < NCHK; p++) begin
            for (int t = 0; t < THREADS; t++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    if (valid_q[t][d] &&
                        (addr_q[t][d] == chk_addr[p*WIDTH +: WIDTH])) begin
                        chk_match_thr[p*THREADS + t] = 1'b1;
                    end
                end
            end
            chk_match[p] = |chk_match_thr[p*THREADS +: THREADS];
        end
    end

    always_comb begin
        full = '0;
        cnt  = '0;
        for (int t = 0; t < THREADS; t++) begin
            full[t]          = (cnt_q[t] == DEPTH_C);
            cnt[t*CW +: CW]  = cnt_q[t];
        end
    end

endmodule

// File: tb/tb_tbufcam_mt.sv
// Testbench for tbufcam_mt (default parameters: 11-bit addresses,
// 2 threads x 4 entries, 2 lookup ports). Directed stimulus pushes the
// hand-computed expected outputs of each cycle into a queue; a monitor on
// the falling edge pops and compares them against the DUT.

module tb_tbufcam_mt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        except = 1'b0;
    logic        except_thread = 1'b0;
    logic        new_en = 1'b0;
    logic [10:0] new_addr = '0;
    logic        new_thread = 1'b0;
    logic        new_ok;
    logic        ret_en = 1'b0;
    logic        ret_thread = 1'b0;
    logic [21:0] chk_addr = '0;
    logic [1:0]  chk_match;
    logic [3:0]  chk_match_thr;
    logic        free;
    logic [1:0]  full;
    logic [5:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       ok;
        logic       fr;
        logic [1:0] m;
        logic [3:0] thr;
        logic [2:0] c0;
        logic [2:0] c1;
    } exp_t;

    exp_t exp_q[$];

    tbufcam_mt dut (
        .clk           (clk),
        .rst           (rst),
        .except        (except),
        .except_thread (except_thread),
        .new_en        (new_en),
        .new_addr      (new_addr),
        .new_thread    (new_thread),
        .new_ok        (new_ok),
        .ret_en        (ret_en),
        .ret_thread    (ret_thread),
        .chk_addr      (chk_addr),
        .chk_match     (chk_match),
        .chk_match_thr (chk_match_thr),
        .free          (free),
        .full          (full),
        .cnt           (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, "new_ok",        32'(new_ok),        32'(e.ok));
            check(e.name, "free",          32'(free),          32'(e.fr));
            check(e.name, "chk_match",     32'(chk_match),     32'(e.m));
            check(e.name, "chk_match_thr", 32'(chk_match_thr), 32'(e.thr));
            check(e.name, "cnt",           32'(cnt),           32'({e.c1, e.c0}));
            check(e.name, "full",          32'(full),
                  32'({e.c1 == 3'd4, e.c0 == 3'd4}));
        end
    end

    // Drive one cycle of inputs, queue its expected outputs, advance.
    task automatic cyc(input string nm, input logic r,
                       input logic ne, input logic [10:0] na, input logic nt,
                       input logic re, input logic rt,
                       input logic ex, input logic et,
                       input logic [10:0] a0, input logic [10:0] a1,
                       input logic eok, input logic efr,
                       input logic [1:0] em, input logic [3:0] ethr,
                       input logic [2:0] ec0, input logic [2:0] ec1);
        exp_t e;
        rst           = r;
        new_en        = ne;
        new_addr      = na;
        new_thread    = nt;
        ret_en        = re;
        ret_thread    = rt;
        except        = ex;
        except_thread = et;
        chk_addr      = {a1, a0};
        e.name = nm; e.ok = eok; e.fr = efr; e.m = em; e.thr = ethr;
        e.c0 = ec0; e.c1 = ec1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        //   name     rst ne addr    nt re rt ex et chk0   chk1    ok fr m     thr      c0 c1
        cyc("reset",  0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h000, 11'h000, 0, 1, 2'b00, 4'b0000, 0, 0);
        // insert visible one cycle later
        cyc("ins123", 0, 1, 11'h123, 0, 0, 0, 0, 0, 11'h123, 11'h000, 1, 1, 2'b00, 4'b0000, 0, 0);
        cyc("hit123", 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h123, 11'h000, 0, 1, 2'b01, 4'b0001, 1, 0);
        // fill thread 1
        cyc("t1_010", 0, 1, 11'h010, 1, 0, 0, 0, 0, 11'h123, 11'h010, 1, 1, 2'b01, 4'b0001, 1, 0);
        cyc("t1_011", 0, 1, 11'h011, 1, 0, 0, 0, 0, 11'h123, 11'h010, 1, 1, 2'b11, 4'b1001, 1, 1);
        cyc("t1_012", 0, 1, 11'h012, 1, 0, 0, 0, 0, 11'h123, 11'h010, 1, 1, 2'b11, 4'b1001, 1, 2);
        cyc("t1_013", 0, 1, 11'h013, 1, 0, 0, 0, 0, 11'h123, 11'h010, 1, 1, 2'b11, 4'b1001, 1, 3);
        cyc("t1_full",0, 1, 11'h014, 1, 0, 0, 0, 0, 11'h123, 11'h010, 0, 0, 2'b11, 4'b1001, 1, 4);
        cyc("t1_stay",0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h014, 11'h013, 0, 1, 2'b10, 4'b1000, 1, 4);
        // duplicate suppression on thread 0
        cyc("dup_a",  0, 1, 11'h055, 0, 0, 0, 0, 0, 11'h055, 11'h000, 1, 1, 2'b00, 4'b0000, 1, 4);
        cyc("dup_b",  0, 1, 11'h055, 0, 0, 0, 0, 0, 11'h055, 11'h000, 1, 1, 2'b01, 4'b0001, 2, 4);
        cyc("flush1", 0, 0, 11'h000, 0, 0, 0, 1, 1, 11'h055, 11'h010, 0, 1, 2'b11, 4'b1001, 2, 4);
        cyc("t1_055", 0, 1, 11'h055, 1, 0, 0, 0, 0, 11'h055, 11'h010, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("both",   0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h055, 11'h010, 0, 1, 2'b01, 4'b0011, 2, 1);
        // flush thread 0 while thread 1 inserts in the same cycle
        cyc("fl0_i1", 0, 1, 11'h7AA, 1, 0, 0, 1, 0, 11'h000, 11'h000, 1, 1, 2'b00, 4'b0000, 2, 1);
        // in-order retire
        cyc("ins_A",  0, 1, 11'h001, 0, 0, 0, 0, 0, 11'h001, 11'h003, 1, 1, 2'b00, 4'b0000, 0, 2);
        cyc("ins_B",  0, 1, 11'h002, 0, 0, 0, 0, 0, 11'h001, 11'h003, 1, 1, 2'b01, 4'b0001, 1, 2);
        cyc("ins_C",  0, 1, 11'h003, 0, 0, 0, 0, 0, 11'h001, 11'h003, 1, 1, 2'b01, 4'b0001, 2, 2);
        cyc("ret_A",  0, 0, 11'h000, 0, 1, 0, 0, 0, 11'h001, 11'h003, 0, 1, 2'b11, 4'b0101, 3, 2);
        cyc("A_gone", 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h001, 11'h002, 0, 1, 2'b10, 4'b0100, 2, 2);
        cyc("ret_B",  0, 0, 11'h000, 0, 1, 0, 0, 0, 11'h002, 11'h003, 0, 1, 2'b11, 4'b0101, 2, 2);
        cyc("ret_C",  0, 0, 11'h000, 0, 1, 0, 0, 0, 11'h002, 11'h003, 0, 1, 2'b10, 4'b0100, 1, 2);
        cyc("ret_emp",0, 0, 11'h000, 0, 1, 0, 0, 0, 11'h002, 11'h003, 0, 1, 2'b00, 4'b0000, 0, 2);
        cyc("empty0", 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h002, 11'h003, 0, 1, 2'b00, 4'b0000, 0, 2);
        // flush thread 1 with a same-cycle insert on thread 1
        cyc("t0_0A1", 0, 1, 11'h0A1, 0, 0, 0, 0, 0, 11'h0A1, 11'h0B1, 1, 1, 2'b00, 4'b0000, 0, 2);
        cyc("t0_0A2", 0, 1, 11'h0A2, 0, 0, 0, 0, 0, 11'h0A1, 11'h0B1, 1, 1, 2'b01, 4'b0001, 1, 2);
        cyc("t1_0B1", 0, 1, 11'h0B1, 1, 0, 0, 0, 0, 11'h0A1, 11'h0B1, 1, 1, 2'b01, 4'b0001, 2, 2);
        cyc("ex1_ins",0, 1, 11'h007, 1, 0, 0, 1, 1, 11'h0A1, 11'h0B1, 0, 1, 2'b11, 4'b1001, 2, 3);
        cyc("ex1_aft",0, 0, 11'h000, 1, 0, 0, 0, 0, 11'h0A1, 11'h0B1, 0, 1, 2'b01, 4'b0001, 2, 0);
        cyc("no_007", 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h0A2, 11'h007, 0, 1, 2'b01, 4'b0001, 2, 0);
        // pointer wrap: simultaneous insert + retire on thread 0
        cyc("wrap1",  0, 1, 11'h101, 0, 1, 0, 0, 0, 11'h0A1, 11'h0A2, 1, 1, 2'b11, 4'b0101, 2, 0);
        cyc("wrap2",  0, 1, 11'h102, 0, 1, 0, 0, 0, 11'h0A2, 11'h0A1, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap3",  0, 1, 11'h103, 0, 1, 0, 0, 0, 11'h101, 11'h0A2, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap4",  0, 1, 11'h104, 0, 1, 0, 0, 0, 11'h102, 11'h101, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap5",  0, 1, 11'h105, 0, 1, 0, 0, 0, 11'h103, 11'h102, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap6",  0, 1, 11'h106, 0, 1, 0, 0, 0, 11'h104, 11'h103, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap7",  0, 1, 11'h107, 0, 1, 0, 0, 0, 11'h105, 11'h104, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap8",  0, 1, 11'h108, 0, 1, 0, 0, 0, 11'h106, 11'h105, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap9",  0, 1, 11'h109, 0, 1, 0, 0, 0, 11'h107, 11'h106, 1, 1, 2'b01, 4'b0001, 2, 0);
        cyc("wrap_lv",0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h108, 11'h109, 0, 1, 2'b11, 4'b0101, 2, 0);
        cyc("wrap_dd",0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h107, 11'h0A1, 0, 1, 2'b00, 4'b0000, 2, 0);
        // full thread: same-cycle retire does not make room for the insert
        cyc("t1_201", 0, 1, 11'h201, 1, 0, 0, 0, 0, 11'h000, 11'h000, 1, 1, 2'b00, 4'b0000, 2, 0);
        cyc("t1_202", 0, 1, 11'h202, 1, 0, 0, 0, 0, 11'h000, 11'h000, 1, 1, 2'b00, 4'b0000, 2, 1);
        cyc("t1_203", 0, 1, 11'h203, 1, 0, 0, 0, 0, 11'h000, 11'h000, 1, 1, 2'b00, 4'b0000, 2, 2);
        cyc("t1_204", 0, 1, 11'h204, 1, 0, 0, 0, 0, 11'h000, 11'h000, 1, 1, 2'b00, 4'b0000, 2, 3);
        cyc("full_rt",0, 1, 11'h205, 1, 1, 1, 0, 0, 11'h000, 11'h000, 0, 0, 2'b00, 4'b0000, 2, 4);
        cyc("aft_frt",0, 0, 11'h000, 1, 0, 0, 0, 0, 11'h201, 11'h202, 0, 1, 2'b10, 4'b1000, 2, 3);
        cyc("pre_rst",0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h108, 11'h203, 0, 1, 2'b11, 4'b1001, 2, 3);
        // asynchronous reset raised between edges, sampled before any edge
        cyc("async_r",1, 0, 11'h000, 0, 0, 0, 0, 0, 11'h108, 11'h203, 0, 1, 2'b00, 4'b0000, 0, 0);
        cyc("post_r", 0, 0, 11'h000, 0, 0, 0, 0, 0, 11'h108, 11'h203, 0, 1, 2'b00, 4'b0000, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
